// File: rtl/mem_stage_mc_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_mc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                dm_req;
    logic                dm_we;
    logic [ADDR_W-1:0]   dm_addr;
    logic [DATA_W-1:0]   dm_wdata;
    logic [DATA_W/8-1:0] dm_byte_en;
    logic [DATA_W-1:0]   dm_rdata;
    logic                dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_byte_en,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_byte_en,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: executes loads/stores over a req/ack memory bus with stall and timeout watchdog.
// Define MEM_SUBWORD_EN to add byte/halfword loads and stores with alignment checking.
module mem_stage_mc #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = $clog2(TIMEOUT+1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_mem_valid,
    input  logic [DATA_W-1:0] EX_MEM_result,
    input  logic [DATA_W-1:0] EX_MEM_B,
    input  logic [4:0]        EX_MEM_dest,
    input  logic [5:0]        EX_MEM_op,
    mem_stage_mc_if.master    dm,
    output logic [DATA_W-1:0] MEM_WB_result,
    output logic [DATA_W-1:0] MEM_WB_data,
    output logic [4:0]        MEM_WB_dest,
    output logic [5:0]        MEM_WB_op,
    output logic              MEM_WB_valid,
    output logic              mem_stall,
    output logic              mem_err
);

    localparam int NB = DATA_W/8;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_p1, state_nxt;
    logic [TO_W-1:0] cnt_p1;

    logic              is_load, is_store, misalign, issue, access, timeout_hit;
    logic [DATA_W-1:0] wdata_fmt;
    logic [NB-1:0]     be_fmt;
    logic [DATA_W-1:0] load_fmt;

`ifdef MEM_SUBWORD_EN
    localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;

    logic [OFF_W-1:0] off;
    assign off = EX_MEM_result[OFF_W-1:0];

    function automatic logic [DATA_W-1:0] store_data(input logic [5:0] op, input logic [DATA_W-1:0] b);
        case (op)
            OP_SB:   return {NB{b[7:0]}};
            OP_SH:   return {(NB/2){b[15:0]}};
            default: return b;
        endcase
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [5:0] op, input logic [OFF_W-1:0] o);
        case (op)
            OP_SB:   return NB'(1) << o;
            OP_SH:   return NB'(3) << o;
            default: return '1;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [DATA_W-1:0] load_extract(input logic [5:0] op, input logic [OFF_W-1:0] o,
                                                       input logic [DATA_W-1:0] rd);
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        b8  = 8'(rd >> {o, 3'b000});
        h16 = 16'(rd >> {o, 3'b000});
        case (op)
            OP_LB:   return {{(DATA_W-8){b8[7]}}, b8};
            OP_LH:   return {{(DATA_W-16){h16[15]}}, h16};
            OP_LBU:  return {{(DATA_W-8){1'b0}}, b8};
            OP_LHU:  return {{(DATA_W-16){1'b0}}, h16};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        if (ex_mem_valid) begin
            case (EX_MEM_op)
                OP_LW:         begin is_load  = 1'b1; misalign = (off != '0); end
                OP_SW:         begin is_store = 1'b1; misalign = (off != '0); end
                OP_LB, OP_LBU: is_load = 1'b1;
                OP_LH, OP_LHU: begin is_load  = 1'b1; misalign = off[0]; end
                OP_SB:         is_store = 1'b1;
                OP_SH:         begin is_store = 1'b1; misalign = off[0]; end
                default:       ;
            endcase
        end
    end

    assign wdata_fmt = store_data(EX_MEM_op, EX_MEM_B);
    assign be_fmt    = lane_mask(EX_MEM_op, off);
    assign load_fmt  = load_extract(EX_MEM_op, off, dm.dm_rdata);
`else
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        if (ex_mem_valid) begin
            case (EX_MEM_op)
                OP_LW:   is_load  = 1'b1;
                OP_SW:   is_store = 1'b1;
                default: ;
            endcase
        end
    end

    assign wdata_fmt = EX_MEM_B;
    assign be_fmt    = '1;
    assign load_fmt  = dm.dm_rdata;
`endif

    assign issue       = (is_load | is_store) & ~misalign;
    assign access      = (state_p1 == ACCESS);
    assign timeout_hit = (cnt_p1 == TO_W'(TIMEOUT-1));

    // An ack in the final watchdog cycle still completes the access.
    always_comb begin
        state_nxt = state_p1;
        mem_stall = 1'b0;
        case (state_p1)
            IDLE: begin
                if (issue) begin
                    state_nxt = ACCESS;
                    mem_stall = 1'b1;
                end
            end
            ACCESS: begin
                if (dm.dm_ack || timeout_hit) state_nxt = IDLE;
                else                          mem_stall = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dm.dm_req     = access;
        dm.dm_we      = access & is_store;
        dm.dm_addr    = access ? ADDR_W'(EX_MEM_result) : '0;
        dm.dm_wdata   = access ? wdata_fmt : '0;
        dm.dm_byte_en = be_fmt;
    end

    // MEM/WB register boundary
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_p1      <= IDLE;
            cnt_p1        <= '0;
            mem_err       <= 1'b0;
            MEM_WB_result <= '0;
            MEM_WB_data   <= '0;
            MEM_WB_dest   <= '0;
            MEM_WB_op     <= '0;
            MEM_WB_valid  <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            case (state_p1)
                IDLE: begin
                    if (issue) begin
                        MEM_WB_valid <= 1'b0;
                        cnt_p1       <= '0;
                    end else begin
                        MEM_WB_result <= EX_MEM_result;
                        MEM_WB_dest   <= EX_MEM_dest;
                        MEM_WB_op     <= EX_MEM_op;
                        MEM_WB_data   <= '0;
                        MEM_WB_valid  <= ex_mem_valid & ~misalign;
                        if (misalign) mem_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (dm.dm_ack) begin
                        MEM_WB_result <= EX_MEM_result;
                        MEM_WB_dest   <= EX_MEM_dest;
                        MEM_WB_op     <= EX_MEM_op;
                        MEM_WB_data   <= is_load ? load_fmt : '0;
                        MEM_WB_valid  <= 1'b1;
                    end else if (timeout_hit) begin
                        mem_err      <= 1'b1;
                        MEM_WB_valid <= 1'b0;
                    end else begin
                        cnt_p1 <= cnt_p1 + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Scoreboard bench for mem_stage_mc: random/directed instructions, modelled memory responder, output monitor.
module tb_mem_stage_mc;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_mem_valid = 1'b0;
    logic [31:0] EX_MEM_result = '0;
    logic [31:0] EX_MEM_B = '0;
    logic [4:0]  EX_MEM_dest = '0;
    logic [5:0]  EX_MEM_op = '0;
    logic [31:0] MEM_WB_result, MEM_WB_data;
    logic [4:0]  MEM_WB_dest;
    logic [5:0]  MEM_WB_op;
    logic        MEM_WB_valid, mem_stall, mem_err;

    mem_stage_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dmif ();

    mem_stage_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .ex_mem_valid(ex_mem_valid),
        .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B), .EX_MEM_dest(EX_MEM_dest),
        .EX_MEM_op(EX_MEM_op), .dm(dmif),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_data(MEM_WB_data), .MEM_WB_dest(MEM_WB_dest),
        .MEM_WB_op(MEM_WB_op), .MEM_WB_valid(MEM_WB_valid), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [31:0] result;
        logic [31:0] data;
        logic [4:0]  dest;
        logic [5:0]  op;
        logic        err;
    } exp_t;

    typedef struct {
        int          delay;   // 0 = never acknowledge
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];
    exp_t exp_last;
    int   errors = 0;
    int   checks = 0;
    logic noise_en = 1'b0;
    logic resp_off = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ISA view: access size in bytes (0 = not a memory op), load and signedness.
    function automatic int acc_size(input logic [5:0] op);
        case (op)
            6'h23, 6'h2B: return 4;
`ifdef MEM_SUBWORD_EN
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == 6'h23) || (op == 6'h20) || (op == 6'h21) || (op == 6'h24) || (op == 6'h25);
    endfunction

    function automatic logic op_is_signed(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21);
    endfunction

    task automatic issue(input logic v, input logic [5:0] op, input logic [31:0] res, input logic [31:0] b,
                         input logic [4:0] dst, input int delay, input logic [31:0] rdata);
        int sz, off, cycles, k;
        logic ld, st, mis;
        logic [31:0] mask, wd, ldv;
        mem_t m;
        @(posedge clock); #1;
        sz   = v ? acc_size(op) : 0;
        ld   = (sz > 0) && op_is_load(op);
        st   = (sz > 0) && !ld;
        mis  = 1'b0;
`ifdef MEM_SUBWORD_EN
        if (sz > 0) mis = (int'(res[1:0]) % sz) != 0;
`endif
        off  = (sz == 4) ? 0 : int'(res[1:0]);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        if (sz == 0 || mis) begin
            exp_last.result = res;
            exp_last.dest   = dst;
            exp_last.op     = op;
            exp_last.data   = '0;
            exp_last.valid  = v && !mis;
            if (mis) exp_last.err = 1'b1;
            cycles = 1;
        end else begin
            wd = '0;
            for (int i = 0; i < 4; i += sz) wd |= (b & mask) << (8*i);
            m.delay = delay;
            m.rdata = rdata;
            m.addr  = res;
            m.we    = st;
            m.wdata = wd;
            m.be    = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << off);
            mem_q.push_back(m);
            if (delay > 0) begin
                ldv = (rdata >> (8*off)) & mask;
                if (op_is_signed(op) && ldv[8*sz-1]) ldv |= ~mask;
                exp_last.result = res;
                exp_last.dest   = dst;
                exp_last.op     = op;
                exp_last.data   = ld ? ldv : 32'h0;
                exp_last.valid  = 1'b1;
                cycles = 1 + delay;
            end else begin
                exp_last.valid = 1'b0;
                exp_last.err   = 1'b1;
                cycles = 1 + TIMEOUT;
            end
        end
        exp_q.push_back(exp_last);
        ex_mem_valid  = v;
        EX_MEM_op     = op;
        EX_MEM_result = res;
        EX_MEM_B      = b;
        EX_MEM_dest   = dst;
        k = 0;
        #7;
        while (mem_stall && k < TIMEOUT + 10) begin
            @(posedge clock); #8;
            k++;
        end
        chk("latency", k + 1, cycles);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            ex_mem_valid = 1'b0;
        end
    endtask

    // Monitor: an instruction retires on each edge that follows a non-stalled sample.
    initial begin
        exp_t pend;
        logic have_pend;
        have_pend = 1'b0;
        forever begin
            @(posedge clock); #8;
            if (have_pend) begin
                chk("wb_valid",  {31'b0, MEM_WB_valid}, {31'b0, pend.valid});
                chk("wb_result", MEM_WB_result, pend.result);
                chk("wb_data",   MEM_WB_data, pend.data);
                chk("wb_dest",   {27'b0, MEM_WB_dest}, {27'b0, pend.dest});
                chk("wb_op",     {26'b0, MEM_WB_op}, {26'b0, pend.op});
                chk("mem_err",   {31'b0, mem_err}, {31'b0, pend.err});
                have_pend = 1'b0;
            end
            if (reset_n && !mem_stall && exp_q.size() > 0) begin
                pend = exp_q.pop_front();
                have_pend = 1'b1;
            end
        end
    end

    // Memory responder with programmed per-access latency; random stray acks while idle.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        dmif.dm_ack   = 1'b0;
        dmif.dm_rdata = '0;
        forever begin
            @(negedge clock);
            dmif.dm_ack = 1'b0;
            if (!resp_off) begin
                if (dmif.dm_req) begin
                    if (mem_q.size() > 0) begin
                        acc_cnt++;
                        if (acc_cnt == 1) begin
                            chk("dm_addr",    dmif.dm_addr, mem_q[0].addr);
                            chk("dm_we",      {31'b0, dmif.dm_we}, {31'b0, mem_q[0].we});
                            chk("dm_wdata",   dmif.dm_wdata, mem_q[0].wdata);
                            chk("dm_byte_en", {28'b0, dmif.dm_byte_en}, {28'b0, mem_q[0].be});
                        end
                        if (mem_q[0].delay == acc_cnt) begin
                            dmif.dm_ack   = 1'b1;
                            dmif.dm_rdata = mem_q[0].rdata;
                            void'(mem_q.pop_front());
                            acc_cnt = 0;
                        end
                    end else begin
                        chk("spurious_dm_req", 32'd1, 32'd0);
                    end
                end else begin
                    chk("idle_bus", dmif.dm_addr | dmif.dm_wdata | {31'b0, dmif.dm_we}, 32'h0);
                    if (acc_cnt > 0) begin
                        chk("req_drop_cycles", acc_cnt, (mem_q[0].delay == 0) ? TIMEOUT : -1);
                        void'(mem_q.pop_front());
                        acc_cnt = 0;
                    end
                    if (noise_en && $urandom_range(7) == 0) begin
                        dmif.dm_ack   = 1'b1;
                        dmif.dm_rdata = $urandom;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int r, w, dly;
        logic [5:0]  op;
        logic [31:0] res;
        exp_last = '{valid: 1'b0, result: 32'h0, data: 32'h0, dest: 5'h0, op: 6'h0, err: 1'b0};

        repeat (2) @(posedge clock);
        #8;
        chk("rst_valid",  {31'b0, MEM_WB_valid}, 32'h0);
        chk("rst_result", MEM_WB_result, 32'h0);
        chk("rst_err",    {31'b0, mem_err}, 32'h0);
        chk("rst_req",    {31'b0, dmif.dm_req}, 32'h0);
        @(posedge clock); #3;
        reset_n = 1'b1;

        issue(1'b1, 6'h00, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        issue(1'b1, 6'h23, 32'h40, 32'h5555_AAAA, 5'd7, 3, 32'hDEAD_BEEF);
        issue(1'b1, 6'h2B, 32'h80, 32'hCAFE_F00D, 5'd2, 1, 32'h0);
        issue(1'b1, 6'h23, 32'h84, 32'h0, 5'd3, 1, 32'h0102_0304);
        issue(1'b0, 6'h23, 32'h4C, 32'h0, 5'd10, 1, 32'h0);
        issue(1'b1, 6'h23, 32'h48, 32'h0, 5'd9, TIMEOUT, 32'h1357_2468);
        issue(1'b1, 6'h23, 32'h44, 32'h0, 5'd8, 0, 32'h0);
        issue(1'b1, 6'h11, 32'h9999, 32'h0, 5'd12, 0, 32'h0);
`ifdef MEM_SUBWORD_EN
        issue(1'b1, 6'h20, 32'h43, 32'h0, 5'd11, 2, 32'h8012_3456);
        issue(1'b1, 6'h24, 32'h43, 32'h0, 5'd11, 1, 32'h8012_3456);
        issue(1'b1, 6'h29, 32'h41, 32'hBEEF, 5'd0, 1, 32'h0);
        issue(1'b1, 6'h28, 32'h42, 32'h0000_00A5, 5'd0, 1, 32'h0);
        issue(1'b1, 6'h21, 32'h42, 32'h0, 5'd13, 1, 32'h8001_1234);
        issue(1'b1, 6'h25, 32'h42, 32'h0, 5'd13, 2, 32'h8001_1234);
        issue(1'b1, 6'h2B, 32'h81, 32'h1, 5'd0, 1, 32'h0);
`else
        issue(1'b1, 6'h20, 32'h43, 32'h0, 5'd11, 1, 32'h0);
        issue(1'b1, 6'h28, 32'h42, 32'h0, 5'd11, 1, 32'h0);
`endif

        noise_en = 1'b1;
        for (int n = 0; n < 250; n++) begin
            r   = $urandom_range(99);
            res = $urandom;
            if (r < 35) begin
                op = 6'($urandom);
                while (acc_size(op) != 0) op = 6'($urandom);
                issue(1'b1, op, res, $urandom, 5'($urandom), 0, 32'h0);
            end else if (r < 45) begin
                issue(1'b0, 6'($urandom), res, $urandom, 5'($urandom), 1, 32'h0);
            end else begin
`ifdef MEM_SUBWORD_EN
                case ($urandom_range(7))
                    0: op = 6'h23; 1: op = 6'h2B; 2: op = 6'h20; 3: op = 6'h21;
                    4: op = 6'h24; 5: op = 6'h25; 6: op = 6'h28; default: op = 6'h29;
                endcase
                if ($urandom_range(1) == 0) res[1:0] = 2'b00;
`else
                op = ($urandom_range(1) == 0) ? 6'h23 : 6'h2B;
`endif
                w = $urandom_range(39);
                dly = (w == 0) ? 0 : (w == 1) ? TIMEOUT : $urandom_range(5, 1);
                issue(1'b1, op, res, $urandom, 5'($urandom), dly, $urandom);
            end
        end
        noise_en = 1'b0;
        idle(3);
        chk("queues_drained", exp_q.size() + mem_q.size(), 0);

        // Reset while an access is outstanding.
        resp_off = 1'b1;
        @(posedge clock); #1;
        ex_mem_valid  = 1'b1;
        EX_MEM_op     = 6'h23;
        EX_MEM_result = 32'h100;
        EX_MEM_dest   = 5'd4;
        w = 0;
        #1;
        while (!dmif.dm_req && w < 10) begin
            @(posedge clock); #2;
            w++;
        end
        chk("req_before_reset", {31'b0, dmif.dm_req}, 32'h1);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("reset_req_drop",  {31'b0, dmif.dm_req}, 32'h0);
        chk("reset_wb_valid",  {31'b0, MEM_WB_valid}, 32'h0);
        chk("reset_wb_result", MEM_WB_result, 32'h0);
        chk("reset_wb_data",   MEM_WB_data, 32'h0);
        chk("reset_wb_dest",   {27'b0, MEM_WB_dest}, 32'h0);
        chk("reset_wb_op",     {26'b0, MEM_WB_op}, 32'h0);
        chk("reset_err",       {31'b0, mem_err}, 32'h0);
        ex_mem_valid = 1'b0;
        @(posedge clock); #3;
        reset_n = 1'b1;
        @(posedge clock); #8;
        chk("idle_after_reset", {31'b0, dmif.dm_req}, 32'h0);
        resp_off = 1'b0;
        exp_last = '{valid: 1'b0, result: 32'h0, data: 32'h0, dest: 5'h0, op: 6'h0, err: 1'b0};
        issue(1'b1, 6'h00, 32'h0000_ABCD, 32'h0, 5'd6, 0, 32'h0);
        issue(1'b1, 6'h2B, 32'h0000_0200, 32'h1122_3344, 5'd0, 1, 32'h0);
        issue(1'b1, 6'h23, 32'h0000_0204, 32'h0, 5'd14, 2, 32'h7654_3210);
        idle(3);
        chk("queues_drained_end", exp_q.size() + mem_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
